iwdg_cfg_master: RTL and testbench

IWDG_CFG_MASTER -- requirements
Module: iwdg_cfg_master

---
 rtl/iwdg_cfg_master.sv | 209 ++++++++++++++++++++
 tb/tb_iwdg_cfg_master.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iwdg_cfg_master.sv
// Wishbone master that unlocks, configures and starts an IWDG, then refreshes it
// periodically until told to stop. Any bus error or exhausted retry/poll budget is fatal.
module iwdg_cfg_master #(
  parameter logic [31:0] BASE_ADR       = 32'h0100_0000,
  parameter int          GRL            = 1,
  parameter int          REFRESH_CYCLES = 1000,
  parameter int          MAX_RETRY      = 3,
  parameter int          ST_POLL_MAX    = 255
) (
  input  logic              clk_m2s,
  input  logic              rst_m2s,
  input  logic              start,
  input  logic              stop,
  input  logic [2:0]        pr_val,
  input  logic [11:0]       rlr_val,
  output logic [31:0]       adr_m2s,
  output logic [31:0]       dat_m2s,
  output logic [GRL:0]      sel_m2s,
  output logic              we_m2s,
  output logic              cyc_m2s,
  output logic              stb_m2s,
  output logic              lok_m2s,
  input  logic [31:0]       dat_s2m,
  input  logic              ack_s2m,
  input  logic              err_s2m,
  input  logic              rty_s2m,
  output logic              running,
  output logic              fault,
  output logic [15:0]       refresh_cnt
);

  localparam logic [31:0] KR_ADR  = BASE_ADR;
  localparam logic [31:0] PR_ADR  = BASE_ADR + 32'h4;
  localparam logic [31:0] RLR_ADR = BASE_ADR + 32'h8;
  localparam logic [31:0] ST_ADR  = BASE_ADR + 32'hC;

  localparam int WCW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int PCW = (ST_POLL_MAX > 0) ? $clog2(ST_POLL_MAX + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_UNLOCK, S_WR_PR, S_WR_RLR, S_POLL_ST, S_START, S_WAIT, S_REFRESH, S_FAULT
  } state_e;

  state_e         state_q, state_d;
  logic           busy_q, busy_d;
  logic [2:0]     pr_q, pr_d;
  logic [11:0]    rlr_q, rlr_d;
  logic [RCW-1:0] retry_q, retry_d;
  logic [PCW-1:0] poll_q, poll_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           running_q, running_d;
  logic [15:0]    refresh_cnt_q, refresh_cnt_d;

  logic take_err, take_ack, take_rty;
  logic unused_st_hi;

  assign unused_st_hi = ^dat_s2m[31:2];

  // NOTE: state flops use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk_m2s or posedge rst_m2s) begin
    if (rst_m2s) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      pr_q          <= '0;
      rlr_q         <= '0;
      retry_q       <= '0;
      poll_q        <= '0;
      wait_q        <= '0;
      running_q     <= 1'b0;
      refresh_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      pr_q          <= pr_d;
      rlr_q         <= rlr_d;
      retry_q       <= retry_d;
      poll_q        <= poll_d;
      wait_q        <= wait_d;
      running_q     <= running_d;
      refresh_cnt_q <= refresh_cnt_d;
    end
  end

  // Terminations only count while a strobe is out; err outranks ack, ack outranks rty.
  assign take_err = busy_q & err_s2m;
  assign take_ack = busy_q & ~err_s2m & ack_s2m;
  assign take_rty = busy_q & ~err_s2m & ~ack_s2m & rty_s2m;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    pr_d          = pr_q;
    rlr_d         = rlr_q;
    retry_d       = retry_q;
    poll_d        = poll_q;
    wait_d        = wait_q;
    running_d     = running_q;
    refresh_cnt_d = refresh_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_UNLOCK;
          busy_d        = 1'b1;
          pr_d          = pr_val;
          rlr_d         = rlr_val;
          retry_d       = '0;
          refresh_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          retry_d = '0;
          if (stop) begin
            state_d   = S_IDLE;
            running_d = 1'b0;
          end else begin
            state_d = S_REFRESH;
            busy_d  = 1'b1;
          end
        end else begin
          wait_d = wait_q - WCW'(1);
        end
      end
      S_FAULT: begin
        busy_d    = 1'b0;
        running_d = 1'b0;
      end
      default: begin
        if (!busy_q) begin
          busy_d = 1'b1;
        end else if (take_err) begin
          state_d   = S_FAULT;
          busy_d    = 1'b0;
          running_d = 1'b0;
        end else if (take_ack) begin
          busy_d  = 1'b0;
          retry_d = '0;
          unique case (state_q)
            S_UNLOCK: state_d = S_WR_PR;
            S_WR_PR:  state_d = S_WR_RLR;
            S_WR_RLR: begin
              state_d = S_POLL_ST;
              poll_d  = '0;
            end
            S_POLL_ST: begin
              if (dat_s2m[1:0] == 2'b00) begin
                state_d = S_START;
              end else if (poll_q == PCW'(ST_POLL_MAX)) begin
                state_d   = S_FAULT;
                running_d = 1'b0;
              end else begin
                poll_d = poll_q + PCW'(1);
              end
            end
            S_START: begin
              state_d   = S_WAIT;
              wait_d    = WCW'(REFRESH_CYCLES - 1);
              running_d = 1'b1;
            end
            S_REFRESH: begin
              state_d = S_WAIT;
              wait_d  = WCW'(REFRESH_CYCLES - 1);
              if (refresh_cnt_q != 16'hFFFF) refresh_cnt_d = refresh_cnt_q + 16'd1;
            end
            default: ;
          endcase
        end else if (take_rty) begin
          busy_d = 1'b0;
          if (retry_q == RCW'(MAX_RETRY)) begin
            state_d   = S_FAULT;
            running_d = 1'b0;
          end else begin
            retry_d = retry_q + RCW'(1);
          end
        end
      end
    endcase
  end

  // Bus fields are decoded from the state, so they stay stable for the whole transfer.
  always_comb begin
    adr_m2s = '0;
    dat_m2s = '0;
    we_m2s  = 1'b0;
    sel_m2s = '1;
    cyc_m2s = busy_q;
    stb_m2s = busy_q;
    lok_m2s = (state_q == S_UNLOCK) || (state_q == S_WR_PR) || (state_q == S_WR_RLR);
    if (busy_q) begin
      unique case (state_q)
        S_UNLOCK:  begin adr_m2s = KR_ADR;  dat_m2s = 32'h0000_5555;     we_m2s = 1'b1; end
        S_WR_PR:   begin adr_m2s = PR_ADR;  dat_m2s = {29'd0, pr_q};     we_m2s = 1'b1; end
        S_WR_RLR:  begin adr_m2s = RLR_ADR; dat_m2s = {20'd0, rlr_q};    we_m2s = 1'b1; end
        S_POLL_ST: begin adr_m2s = ST_ADR; end
        S_START:   begin adr_m2s = KR_ADR;  dat_m2s = 32'h0000_CCCC;     we_m2s = 1'b1; end
        S_REFRESH: begin adr_m2s = KR_ADR;  dat_m2s = 32'h0000_AAAA;     we_m2s = 1'b1; end
        default: ;
      endcase
    end
  end

  assign running     = running_q;
  assign fault       = (state_q == S_FAULT);
  assign refresh_cnt = refresh_cnt_q;

endmodule

// File: tb/tb_iwdg_cfg_master.sv
// Scoreboard bench for iwdg_cfg_master: stimulus queues expected bus transfers and slave
// responses; a monitor compares each strobed transfer against the queue head.
module tb_iwdg_cfg_master;

  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [31:0] KR   = BASE;
  localparam logic [31:0] PR   = BASE + 32'h4;
  localparam logic [31:0] RLR  = BASE + 32'h8;
  localparam logic [31:0] ST   = BASE + 32'hC;

  logic        clk_m2s = 1'b0;
  logic        rst_m2s = 1'b1;
  logic        start = 1'b0, stop = 1'b0;
  logic [2:0]  pr_val = '0;
  logic [11:0] rlr_val = '0;
  logic [31:0] adr_m2s, dat_m2s;
  logic [1:0]  sel_m2s;
  logic        we_m2s, cyc_m2s, stb_m2s, lok_m2s;
  logic [31:0] dat_s2m = '0;
  logic        ack_s2m = 1'b0, err_s2m = 1'b0, rty_s2m = 1'b0;
  logic        running, fault;
  logic [15:0] refresh_cnt;

  typedef enum {R_ACK, R_RTY, R_ERR_ALL, R_ACK_RTY} resp_e;
  typedef struct {resp_e kind; logic [31:0] rdata;} resp_t;
  typedef struct {logic [31:0] adr; logic [31:0] dat; logic we; logic lok; int gap;} xfer_t;

  resp_t rsp_q[$];
  xfer_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  bit    spurious = 1'b0;

  always #5 clk_m2s = ~clk_m2s;

  iwdg_cfg_master #(
    .BASE_ADR(BASE), .GRL(1), .REFRESH_CYCLES(10), .MAX_RETRY(3), .ST_POLL_MAX(3)
  ) dut (
    .clk_m2s(clk_m2s), .rst_m2s(rst_m2s), .start(start), .stop(stop),
    .pr_val(pr_val), .rlr_val(rlr_val),
    .adr_m2s(adr_m2s), .dat_m2s(dat_m2s), .sel_m2s(sel_m2s), .we_m2s(we_m2s),
    .cyc_m2s(cyc_m2s), .stb_m2s(stb_m2s), .lok_m2s(lok_m2s),
    .dat_s2m(dat_s2m), .ack_s2m(ack_s2m), .err_s2m(err_s2m), .rty_s2m(rty_s2m),
    .running(running), .fault(fault), .refresh_cnt(refresh_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Slave: answers every strobed negedge from the response script (default plain ack).
  always @(negedge clk_m2s) begin
    resp_t r;
    ack_s2m = 1'b0; err_s2m = 1'b0; rty_s2m = 1'b0; dat_s2m = '0;
    if (stb_m2s) begin
      if (rsp_q.size() != 0) r = rsp_q.pop_front();
      else begin r.kind = R_ACK; r.rdata = '0; end
      dat_s2m = r.rdata;
      case (r.kind)
        R_ACK:     ack_s2m = 1'b1;
        R_RTY:     rty_s2m = 1'b1;
        R_ERR_ALL: begin err_s2m = 1'b1; ack_s2m = 1'b1; rty_s2m = 1'b1; end
        R_ACK_RTY: begin ack_s2m = 1'b1; rty_s2m = 1'b1; end
        default:   ack_s2m = 1'b1;
      endcase
    end else if (spurious) begin
      ack_s2m = 1'b1;
      rty_s2m = 1'b1;
    end
  end

  // Monitor: every strobed cycle is one transfer attempt; compare with the queue head.
  int gap_cnt = 0;
  always @(negedge clk_m2s) begin
    xfer_t e;
    if (rst_m2s) begin
      gap_cnt = 0;
    end else if (stb_m2s) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_xfer: got adr=%h dat=%h required no transfer at %0t",
                 adr_m2s, dat_m2s, $time);
      end else begin
        e = exp_q.pop_front();
        check("adr", adr_m2s, e.adr);
        check("dat", dat_m2s, e.dat);
        check("we", we_m2s, e.we);
        check("lok", lok_m2s, e.lok);
        check("cyc", cyc_m2s, 1);
        check("sel", sel_m2s, 2'b11);
        if (e.gap >= 0) check("gap", gap_cnt, e.gap);
      end
      gap_cnt = 0;
    end else begin
      gap_cnt++;
    end
  end

  task automatic xp(input logic [31:0] a, input logic [31:0] d, input logic we, input logic lok,
                    input int gap);
    xfer_t e;
    e.adr = a; e.dat = d; e.we = we; e.lok = lok; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic rp(input resp_e k, input logic [31:0] d);
    resp_t r;
    r.kind = k; r.rdata = d;
    rsp_q.push_back(r);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_m2s);
    #1;
  endtask

  task automatic pulse_start(input logic [2:0] pr, input logic [11:0] rlr);
    @(negedge clk_m2s); #1;
    start = 1'b1; pr_val = pr; rlr_val = rlr;
    @(negedge clk_m2s); #1;
    start = 1'b0; pr_val = ~pr; rlr_val = ~rlr;
  endtask

  task automatic drain(input string name, input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk_m2s); #1;
      i++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk_m2s); #1;
    rst_m2s = 1'b1; start = 1'b0; stop = 1'b0; spurious = 1'b0;
    rsp_q.delete();
    cycles(2);
    rst_m2s = 1'b0;
    cycles(2);
  endtask

  // Full config expectation with plain acks and ST returning zero on the first read.
  task automatic cfg_expect(input logic [2:0] pr, input logic [11:0] rlr);
    xp(KR,  32'h5555,      1, 1, -1);
    xp(PR,  {29'd0, pr},   1, 1, 1);
    xp(RLR, {20'd0, rlr},  1, 1, 1);
    xp(ST,  32'h0,         0, 0, 1);
    xp(KR,  32'hCCCC,      1, 0, 1);
  endtask

  initial begin
    bit found;
    #12;
    check("rst_cyc", cyc_m2s, 0);
    check("rst_stb", stb_m2s, 0);
    check("rst_we", we_m2s, 0);
    check("rst_lok", lok_m2s, 0);
    check("rst_adr", adr_m2s, 0);
    check("rst_dat", dat_m2s, 0);
    check("rst_sel", sel_m2s, 2'b11);
    check("rst_running", running, 0);
    check("rst_fault", fault, 0);
    check("rst_refresh_cnt", refresh_cnt, 0);
    @(negedge clk_m2s); #1;
    rst_m2s = 1'b0;
    cycles(6);
    check("quiet_after_reset", stb_m2s, 0);

    // Nominal config, three refreshes, stop raised while the last refresh is in flight.
    cfg_expect(3'd4, 12'hFFF);
    pulse_start(3'd4, 12'hFFF);
    drain("cfg", 60);
    cycles(2);
    check("running_after_start", running, 1);
    check("lok_after_cfg", lok_m2s, 0);
    check("refresh_cnt_0", refresh_cnt, 0);
    xp(KR, 32'hAAAA, 1, 0, 10);
    pulse_start(3'd1, 12'h001);
    drain("refresh1", 30);
    cycles(2);
    check("refresh_cnt_1", refresh_cnt, 1);
    xp(KR, 32'hAAAA, 1, 0, 10);
    drain("refresh2", 30);
    cycles(2);
    check("refresh_cnt_2", refresh_cnt, 2);
    xp(KR, 32'hAAAA, 1, 0, 10);
    drain("refresh3", 30);
    stop = 1'b1;
    cycles(2);
    check("refresh_cnt_3", refresh_cnt, 3);
    check("running_before_stop", running, 1);
    cycles(14);
    check("running_after_stop", running, 0);
    check("refresh_cnt_kept", refresh_cnt, 3);
    stop = 1'b0;

    // Retries on PR, ack+rty on RLR, ST busy three times, spurious idle terminations.
    spurious = 1'b1;
    xp(KR, 32'h5555, 1, 1, -1);  rp(R_ACK, 0);
    xp(PR, 32'h2, 1, 1, 1);      rp(R_RTY, 0);
    xp(PR, 32'h2, 1, 1, 1);      rp(R_RTY, 0);
    xp(PR, 32'h2, 1, 1, 1);      rp(R_ACK, 0);
    xp(RLR, 32'h123, 1, 1, 1);   rp(R_ACK_RTY, 0);
    xp(ST, 32'h0, 0, 0, 1);      rp(R_ACK, 32'h0000_0001);
    xp(ST, 32'h0, 0, 0, 1);      rp(R_ACK, 32'h0000_0005);
    xp(ST, 32'h0, 0, 0, 1);      rp(R_ACK, 32'hFFFF_FFFD);
    xp(ST, 32'h0, 0, 0, 1);      rp(R_ACK, 32'hFFFF_FFFC);
    xp(KR, 32'hCCCC, 1, 0, 1);   rp(R_ACK, 0);
    pulse_start(3'd2, 12'h123);
    check("refresh_cnt_cleared", refresh_cnt, 0);
    check("lok_unlock", lok_m2s, 1);
    drain("retry_poll", 80);
    stop = 1'b1;
    cycles(2);
    check("running_after_poll", running, 1);
    check("fault_after_poll", fault, 0);
    cycles(15);
    check("idle_after_poll", running, 0);
    stop = 1'b0;
    spurious = 1'b0;

    // Fourth consecutive rty on PR is fatal.
    xp(KR, 32'h5555, 1, 1, -1);  rp(R_ACK, 0);
    for (int i = 0; i < 4; i++) begin
      xp(PR, 32'h5, 1, 1, 1);
      rp(R_RTY, 0);
    end
    pulse_start(3'd5, 12'h010);
    drain("retry_fault", 40);
    cycles(2);
    check("retry_fault", fault, 1);
    check("retry_fault_cyc", cyc_m2s, 0);
    check("retry_fault_lok", lok_m2s, 0);
    do_reset();
    check("fault_cleared_by_reset", fault, 0);

    // err (with ack and rty also raised) on UNLOCK; start is ignored afterwards.
    xp(KR, 32'h5555, 1, 1, -1);  rp(R_ERR_ALL, 0);
    pulse_start(3'd1, 12'h001);
    drain("err", 10);
    cycles(1);
    check("err_fault", fault, 1);
    check("err_cyc", cyc_m2s, 0);
    pulse_start(3'd3, 12'h003);
    cycles(10);
    check("fault_sticky", fault, 1);
    check("fault_no_stb", stb_m2s, 0);
    do_reset();

    // ST stays busy past the poll budget.
    xp(KR, 32'h5555, 1, 1, -1);  rp(R_ACK, 0);
    xp(PR, 32'h6, 1, 1, 1);      rp(R_ACK, 0);
    xp(RLR, 32'h0AB, 1, 1, 1);   rp(R_ACK, 0);
    for (int i = 0; i < 4; i++) begin
      xp(ST, 32'h0, 0, 0, 1);
      rp(R_ACK, 32'h1);
    end
    pulse_start(3'd6, 12'h0AB);
    drain("poll_fault", 60);
    cycles(2);
    check("poll_fault", fault, 1);
    check("poll_fault_running", running, 0);
    do_reset();

    // Asynchronous reset in the middle of a refresh transfer.
    cfg_expect(3'd7, 12'h800);
    xp(KR, 32'hAAAA, 1, 0, 10);
    pulse_start(3'd7, 12'h800);
    drain("pre_reset", 60);
    cycles(2);
    check("pre_reset_cnt", refresh_cnt, 1);
    xp(KR, 32'hAAAA, 1, 0, 10);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_m2s); #1;
      if (stb_m2s) found = 1'b1;
    end
    check("refresh_seen", found, 1);
    check("pre_reset_running", running, 1);
    rst_m2s = 1'b1;
    #1;
    check("async_rst_cyc", cyc_m2s, 0);
    check("async_rst_stb", stb_m2s, 0);
    check("async_rst_running", running, 0);
    check("async_rst_refresh_cnt", refresh_cnt, 0);
    cycles(2);
    rst_m2s = 1'b0;
    cycles(8);
    check("quiet_after_async_rst", stb_m2s, 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
